fetch_prefetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the single-cycle datapath's instruction path.
- Generates sequential fetch addresses and issues one-outstanding requests to a variable-latency instruction memory.
- Buffers returned words with their PCs in a small FIFO.
- Presents them to the datapath with a valid/ready handshake; a redirect (taken branch/jump) flushes the buffer and restarts fetch at a new PC.

---
 rtl/fetch_prefetch_queue_if.sv | 26 ++
 rtl/fetch_prefetch_queue.sv | 180 ++++++++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bus: instruction-memory request/ack, redirect, and the
// valid/ready instruction stream toward the datapath.
interface fetch_prefetch_queue_if;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_ready_i;

   // Fetch unit view
   modport master (
      output mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o,
      input  mem_ack_i, mem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
   );

   // Memory + datapath view
   modport slave (
      input  mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o,
      output mem_ack_i, mem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
   );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher: one outstanding memory request, a small
// PC/word FIFO, redirect flush. Optional same-cycle bypass: FETCH_BYPASS_EN.
module fetch_prefetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clock_i,
   input  logic                   reset_i,
   fetch_prefetch_queue_if.master bus_io
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [31:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      DISCARD = 2'd2
   } state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } entry_t;

   state_e        state_q, state_d;
   logic          mem_req_q, mem_req_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   entry_t        fifo_q [DEPTH];

   entry_t        head_c;
   logic [31:0]   redirect_pc_c;
   logic          ack_req_c;
   logic          fifo_valid_c;
   logic          bypass_c;
   logic          push_c;
   logic          pop_c;
   logic [CW:0]   occ_next_c;
   logic          space_c;

   assign redirect_pc_c = bus_io.redirect_pc_i & ~32'h0000_0003;
   assign ack_req_c     = (state_q == REQ) && bus_io.mem_ack_i;
   assign fifo_valid_c  = (count_q != '0);
   assign head_c        = fifo_q[rd_ptr_q];

   // Returned word goes straight out when nothing is queued ahead of it
`ifdef FETCH_BYPASS_EN
   assign bypass_c = ack_req_c && !bus_io.redirect_i && !fifo_valid_c;
`else
   assign bypass_c = 1'b0;
`endif

   assign pop_c  = fifo_valid_c && bus_io.instr_ready_i && !bus_io.redirect_i;
   assign push_c = ack_req_c && !bus_io.redirect_i &&
                   !(bypass_c && bus_io.instr_ready_i);

   assign occ_next_c = {1'b0, count_q}
                     + {{CW{1'b0}}, push_c}
                     - {{CW{1'b0}}, pop_c};
   assign space_c    = (occ_next_c < (CW+1)'(DEPTH));

   assign bus_io.mem_req_o     = mem_req_q;
   assign bus_io.mem_addr_o    = mem_addr_q;
   assign bus_io.instr_valid_o = fifo_valid_c || bypass_c;
   assign bus_io.instr_o       = fifo_valid_c ? head_c.word :
                                 (bypass_c ? bus_io.mem_rdata_i : 32'h0);
   assign bus_io.instr_pc_o    = fifo_valid_c ? head_c.pc :
                                 (bypass_c ? mem_addr_q : 32'h0);

   // Request FSM: next state and registered memory-side outputs
   always_comb begin
      state_d    = state_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      fetch_pc_d = fetch_pc_q;

      unique case (state_q)
         IDLE: begin
            if (bus_io.redirect_i) begin
               fetch_pc_d = redirect_pc_c;
               state_d    = REQ;
               mem_req_d  = 1'b1;
               mem_addr_d = redirect_pc_c;
            end else if (space_c) begin
               state_d    = REQ;
               mem_req_d  = 1'b1;
               mem_addr_d = fetch_pc_q;
            end
         end

         REQ: begin
            if (bus_io.redirect_i) begin
               fetch_pc_d = redirect_pc_c;
               if (bus_io.mem_ack_i) begin
                  mem_addr_d = redirect_pc_c;
               end else begin
                  // Address must stay stable until the stale request acks
                  state_d = DISCARD;
               end
            end else if (bus_io.mem_ack_i) begin
               fetch_pc_d = fetch_pc_q + 32'd4;
               if (space_c) begin
                  mem_addr_d = fetch_pc_q + 32'd4;
               end else begin
                  state_d   = IDLE;
                  mem_req_d = 1'b0;
               end
            end
         end

         DISCARD: begin
            if (bus_io.redirect_i) begin
               fetch_pc_d = redirect_pc_c;
            end
            if (bus_io.mem_ack_i) begin
               state_d    = REQ;
               mem_addr_d = bus_io.redirect_i ? redirect_pc_c : fetch_pc_q;
            end
         end

         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // FIFO pointer/occupancy update; redirect empties the queue
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (bus_io.redirect_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = occ_next_c[CW-1:0];
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         mem_req_q  <= 1'b0;
         mem_addr_q <= RESET_PC_A;
         fetch_pc_q <= RESET_PC_A;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage needs no reset: entries are only observed while counted valid
   always_ff @(posedge clock_i) begin
      if (push_c) begin
         fifo_q[wr_ptr_q] <= '{pc: mem_addr_q, word: bus_io.mem_rdata_i};
      end
   end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Scoreboard bench for fetch_prefetch_queue: directed fetch, backpressure,
// redirect, reset and wrap scenarios; a negedge monitor checks every output.
module tb_fetch_prefetch_queue;

   localparam int unsigned DEPTH = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   logic   clock = 1'b0;
   logic   reset;
   int     n_checks = 0;
   int     n_fail   = 0;
   int     n_out    = 0;
   int     base;
   exp_t   exp_q[$];
   exp_t   mon_e;

   fetch_prefetch_queue_if bus ();

   fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
      .clock_i (clock),
      .reset_i (reset),
      .bus_io  (bus.master)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] dw(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.mem_ack_i     = 1'b0;
      bus.mem_rdata_i   = 32'h0;
      bus.redirect_i    = 1'b0;
      bus.redirect_pc_i = 32'h0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.instr_ready_i = 1'b0;
      idle_inputs();
      exp_q.delete();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic ack_word(input logic [31:0] addr, input logic [31:0] data);
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = data;
      exp_q.push_back('{pc: addr, word: data});
   endtask

   task automatic drain(input int n);
      idle_inputs();
      bus.instr_ready_i = 1'b1;
      repeat (n) tick();
   endtask

   // Monitor: every accepted instruction must match the head of the scoreboard
   always @(negedge clock) begin
      if (!reset && bus.instr_valid_o && bus.instr_ready_i && !bus.redirect_i) begin
         n_out++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got pc %h word %h, expected no output",
                     bus.instr_pc_o, bus.instr_o);
         end else begin
            mon_e = exp_q.pop_front();
            check("sb_pc", bus.instr_pc_o, mon_e.pc);
            check("sb_word", bus.instr_o, mon_e.word);
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      bus.instr_ready_i = 1'b0;
      idle_inputs();

      // Reset values, then zero-wait streaming with continuous ready
      do_reset();
      check("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
      check("rst_mem_addr", bus.mem_addr_o, 32'h0);
      check("rst_valid", 32'(bus.instr_valid_o), 32'd0);
      check("rst_instr", bus.instr_o, 32'h0);
      check("rst_pc", bus.instr_pc_o, 32'h0);
      bus.instr_ready_i = 1'b1;
      tick();
      base = n_out;
      for (int i = 0; i < 8; i++) begin
         check("t1_req", 32'(bus.mem_req_o), 32'd1);
         check("t1_addr", bus.mem_addr_o, 32'(i * 4));
         ack_word(32'(i * 4), dw(32'(i * 4)));
         tick();
      end
      idle_inputs();
      tick();
      check("t1_out_count", 32'(n_out - base), 32'd8);
      check("t1_valid_after", 32'(bus.instr_valid_o), 32'd0);
      check("t1_addr_after", bus.mem_addr_o, 32'h20);
      check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

      // Backpressure: exactly DEPTH words accepted, then resume at 0x10
      do_reset();
      tick();
      for (int i = 0; i < 4; i++) begin
         check("t2_req", 32'(bus.mem_req_o), 32'd1);
         check("t2_addr", bus.mem_addr_o, 32'(i * 4));
         ack_word(32'(i * 4), dw(32'(i * 4)));
         tick();
      end
      idle_inputs();
      check("t2_req_drop", 32'(bus.mem_req_o), 32'd0);
      check("t2_valid_held", 32'(bus.instr_valid_o), 32'd1);
      check("t2_head_pc", bus.instr_pc_o, 32'h0);
      check("t2_head_word", bus.instr_o, dw(32'h0));
      tick();
      check("t2_req_still_low", 32'(bus.mem_req_o), 32'd0);
      check("t2_head_pc_held", bus.instr_pc_o, 32'h0);
      bus.instr_ready_i = 1'b1;
      tick();
      for (int i = 4; i < 6; i++) begin
         check("t2_resume_req", 32'(bus.mem_req_o), 32'd1);
         check("t2_resume_addr", bus.mem_addr_o, 32'(i * 4));
         ack_word(32'(i * 4), dw(32'(i * 4)));
         tick();
      end
      drain(6);
      check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

      // Redirect while a slow request is outstanding
      do_reset();
      bus.instr_ready_i = 1'b1;
      tick();
      ack_word(32'h0, dw(32'h0));
      tick();
      ack_word(32'h4, dw(32'h4));
      tick();
      idle_inputs();
      check("t3_wait1_addr", bus.mem_addr_o, 32'h8);
      tick();
      check("t3_wait2_addr", bus.mem_addr_o, 32'h8);
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'h100;
      exp_q.delete();
      tick();
      idle_inputs();
      check("t3_discard_req", 32'(bus.mem_req_o), 32'd1);
      check("t3_discard_addr", bus.mem_addr_o, 32'h8);
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = dw(32'h8);
      tick();
      idle_inputs();
      check("t3_new_req", 32'(bus.mem_req_o), 32'd1);
      check("t3_new_addr", bus.mem_addr_o, 32'h100);
      check("t3_dropped", 32'(bus.instr_valid_o), 32'd0);
      ack_word(32'h100, dw(32'h100));
      tick();
      drain(3);
      check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

      // Redirect coincident with ack and pop, two entries queued
      do_reset();
      tick();
      ack_word(32'h0, dw(32'h0));
      tick();
      ack_word(32'h4, dw(32'h4));
      tick();
      check("t4_two_queued", 32'(bus.instr_valid_o), 32'd1);
      check("t4_addr", bus.mem_addr_o, 32'h8);
      bus.instr_ready_i = 1'b1;
      bus.mem_ack_i     = 1'b1;
      bus.mem_rdata_i   = dw(32'h8);
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'h203;
      exp_q.delete();
      tick();
      idle_inputs();
      check("t4_flushed", 32'(bus.instr_valid_o), 32'd0);
      check("t4_req", 32'(bus.mem_req_o), 32'd1);
      check("t4_addr_redir", bus.mem_addr_o, 32'h200);
      ack_word(32'h200, dw(32'h200));
      tick();
      drain(3);
      check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

      // Reset with an outstanding request and three queued entries
      do_reset();
      tick();
      for (int i = 0; i < 3; i++) begin
         ack_word(32'(i * 4), dw(32'(i * 4)));
         tick();
      end
      idle_inputs();
      check("t5_req_out", 32'(bus.mem_req_o), 32'd1);
      check("t5_addr_out", bus.mem_addr_o, 32'hC);
      tick();
      reset = 1'b1;
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = dw(32'hC);
      exp_q.delete();
      tick();
      check("t5_rst_req", 32'(bus.mem_req_o), 32'd0);
      check("t5_rst_valid", 32'(bus.instr_valid_o), 32'd0);
      check("t5_rst_addr", bus.mem_addr_o, 32'h0);
      check("t5_rst_instr", bus.instr_o, 32'h0);
      check("t5_rst_pc", bus.instr_pc_o, 32'h0);
      reset = 1'b0;
      tick();
      idle_inputs();
      check("t5_late_req", 32'(bus.mem_req_o), 32'd1);
      check("t5_late_addr", bus.mem_addr_o, 32'h0);
      check("t5_late_ignored", 32'(bus.instr_valid_o), 32'd0);
      bus.instr_ready_i = 1'b1;
      ack_word(32'h0, dw(32'h0));
      tick();
      drain(3);
      check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

      // Ack latency into an empty FIFO, reached through an IDLE redirect
      do_reset();
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'h40;
      tick();
      idle_inputs();
      check("t6_req", 32'(bus.mem_req_o), 32'd1);
      check("t6_addr", bus.mem_addr_o, 32'h40);
      bus.instr_ready_i = 1'b1;
      ack_word(32'h40, 32'h8C00_0000);
      #1;
`ifdef FETCH_BYPASS_EN
      check("t6_bypass_valid", 32'(bus.instr_valid_o), 32'd1);
      check("t6_bypass_instr", bus.instr_o, 32'h8C00_0000);
      check("t6_bypass_pc", bus.instr_pc_o, 32'h40);
`else
      check("t6_ack_cycle_valid", 32'(bus.instr_valid_o), 32'd0);
`endif
      tick();
      idle_inputs();
`ifdef FETCH_BYPASS_EN
      check("t6_next_valid", 32'(bus.instr_valid_o), 32'd0);
`else
      check("t6_next_valid", 32'(bus.instr_valid_o), 32'd1);
      check("t6_next_instr", bus.instr_o, 32'h8C00_0000);
      check("t6_next_pc", bus.instr_pc_o, 32'h40);
`endif
      drain(2);
      check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

      // Redirect with ack to the top of the address space; fetch PC wraps
      check("t7_addr_start", bus.mem_addr_o, 32'h44);
      bus.mem_ack_i     = 1'b1;
      bus.mem_rdata_i   = dw(32'h44);
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'hFFFF_FFFE;
      tick();
      idle_inputs();
      check("t7_addr_top", bus.mem_addr_o, 32'hFFFF_FFFC);
      ack_word(32'hFFFF_FFFC, dw(32'hFFFF_FFFC));
      tick();
      idle_inputs();
      check("t7_addr_wrap", bus.mem_addr_o, 32'h0);
      ack_word(32'h0, dw(32'h0));
      tick();
      drain(3);
      check("t7_sb_empty", 32'(exp_q.size()), 32'd0);

      // Back-to-back redirects while discarding
      check("t8_addr_start", bus.mem_addr_o, 32'h4);
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'h300;
      tick();
      bus.redirect_pc_i = 32'h400;
      tick();
      idle_inputs();
      check("t8_discard_req", 32'(bus.mem_req_o), 32'd1);
      check("t8_discard_addr", bus.mem_addr_o, 32'h4);
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = dw(32'h4);
      tick();
      idle_inputs();
      check("t8_new_addr", bus.mem_addr_o, 32'h400);
      check("t8_dropped", 32'(bus.instr_valid_o), 32'd0);
      ack_word(32'h400, dw(32'h400));
      tick();
      drain(3);
      check("t8_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
